srio_nwr_req: RTL and testbench

Initiator-side SRIO request engine between the Xilinx SRIO Gen2 core's HELLO-format initiator ports (ireq/iresp) and the application. After link-up it runs a doorbell self-check to establish "RapidIO ready". It then issues NWRITE_R packets on request. Each packet's payload comes from an internal deterministic data generator, and the engine waits for each packet's response before accepting the next request.

---
 rtl/srio_nwr_req.sv | 164 ++++++++++++++++
 tb/tb_srio_nwr_req.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/srio_nwr_req.sv
// ---------------------------------------------------------------------------
// srio_nwr_req
// Initiator-side request engine for the SRIO Gen2 HELLO initiator ports.
// After link-up a doorbell self-check establishes "RapidIO ready"; then each
// nwr_req_in pulse issues one NWRITE_R (header + NWR_BEATS generated data
// beats) and waits for its response before the next request is accepted.
//
// Ports
//   log_clk / log_rst_n      clock, async active-low reset
//   src_id / des_id          device IDs, driven on ireq_tuser_o
//   link_initialized         link up; low forces IDLE and abandons a packet
//   self_check_in            pulse: start doorbell self-check (IDLE only)
//   nwr_req_in               pulse: issue one NWRITE_R (READY only)
//   rapidIO_ready_o          self-check passed
//   nwr_ready_o / nwr_busy_o request can be accepted / NWRITE in progress
//   nwr_done_o               one-cycle pulse on NWRITE response
//   ireq_*                   AXI-S request stream (HELLO format)
//   iresp_*                  AXI-S response stream (always ready)
// ---------------------------------------------------------------------------
module srio_nwr_req #(
    parameter int          NWR_BEATS    = 32,
    parameter logic [33:0] USER_ADDR    = 34'h0,
    parameter logic [15:0] DB_INFO      = 16'h0100,
    parameter int          RESP_TIMEOUT = 1024
) (
    input  logic        log_clk,
    input  logic        log_rst_n,
    input  logic [15:0] src_id,
    input  logic [15:0] des_id,
    input  logic        link_initialized,
    input  logic        self_check_in,
    input  logic        nwr_req_in,
    output logic        rapidIO_ready_o,
    output logic        nwr_ready_o,
    output logic        nwr_busy_o,
    output logic        nwr_done_o,
    output logic        ireq_tvalid_o,
    input  logic        ireq_tready_in,
    output logic        ireq_tlast_o,
    output logic [63:0] ireq_tdata_o,
    output logic [7:0]  ireq_tkeep_o,
    output logic [31:0] ireq_tuser_o,
    input  logic        iresp_tvalid_in,
    output logic        iresp_tready_o,
    input  logic        iresp_tlast_in,
    input  logic [63:0] iresp_tdata_in,
    input  logic [7:0]  iresp_tkeep_in,
    input  logic [31:0] iresp_tuser_in
);

    localparam int         BW       = (NWR_BEATS > 1) ? $clog2(NWR_BEATS) : 1;
    localparam int         TW       = $clog2(RESP_TIMEOUT + 1);
    localparam logic [7:0] NWR_SIZE = 8'(NWR_BEATS * 8 - 1);

    typedef enum logic [2:0] {
        IDLE, DB_SEND, DB_WAIT, READY, NWR_HDR, NWR_DATA, NWR_WAIT
    } state_t;

    state_t          state, nxt;
    logic [7:0]      tid;       // TID for the next request
    logic [7:0]      wait_tid;  // TID of the outstanding request
    logic [15:0]     pkt_cnt;
    logic [BW-1:0]   beat_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            fire, last_beat, resp_ok, tmo_hit, sent;
    logic [33:0]     nwr_addr;

    // Response fields not needed for matching are sunk here.
    logic unused_resp;
    assign unused_resp = ^{iresp_tlast_in, iresp_tkeep_in, iresp_tuser_in, iresp_tdata_in[47:0]};

    // tvalid is gated by the link so a link drop withdraws the beat at once.
    assign ireq_tvalid_o = (state == DB_SEND || state == NWR_HDR || state == NWR_DATA)
                           && link_initialized;
    assign fire      = ireq_tvalid_o && ireq_tready_in;
    assign last_beat = (beat_cnt == BW'(NWR_BEATS - 1));
    assign sent      = fire && (state == DB_SEND || (state == NWR_DATA && last_beat));
    assign resp_ok   = iresp_tvalid_in && iresp_tready_o
                       && iresp_tdata_in[55:48] == 8'hD0
                       && iresp_tdata_in[63:56] == wait_tid;
    // Counter is 0 in the first wait cycle, so this allows RESP_TIMEOUT cycles.
    assign tmo_hit   = (tmo_cnt == TW'(RESP_TIMEOUT - 1));
    assign nwr_addr  = USER_ADDR + 34'(pkt_cnt) * 34'(NWR_BEATS * 8);

    assign rapidIO_ready_o = (state == READY) || nwr_busy_o;
    assign nwr_ready_o     = (state == READY);
    assign nwr_busy_o      = (state == NWR_HDR) || (state == NWR_DATA) || (state == NWR_WAIT);
    assign ireq_tkeep_o    = ireq_tvalid_o ? 8'hFF : 8'h00;
    assign ireq_tuser_o    = ireq_tvalid_o ? {src_id, des_id} : 32'h0;

    always_comb begin
        ireq_tdata_o = '0;
        ireq_tlast_o = 1'b0;
        case (state)
            DB_SEND: begin
                ireq_tdata_o = {tid, 4'hA, 4'h0, 1'b0, 2'b01, 1'b0, 8'h00,
                                2'b00, 2'b00, DB_INFO, 16'h0000};
                ireq_tlast_o = 1'b1;
            end
            NWR_HDR:
                ireq_tdata_o = {tid, 4'h5, 4'h5, 1'b0, 2'b01, 1'b0, NWR_SIZE,
                                2'b00, nwr_addr};
            NWR_DATA: begin
                ireq_tdata_o = {src_id, des_id, pkt_cnt, 16'(beat_cnt)};
                ireq_tlast_o = last_beat;
            end
            default: ;
        endcase
        if (!link_initialized) begin
            ireq_tdata_o = '0;
            ireq_tlast_o = 1'b0;
        end
    end

    always_comb begin
        nxt = state;
        if (!link_initialized) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (self_check_in) nxt = DB_SEND;
                DB_SEND:  if (fire) nxt = DB_WAIT;
                DB_WAIT:  if (resp_ok) nxt = READY; else if (tmo_hit) nxt = IDLE;
                READY:    if (nwr_req_in) nxt = NWR_HDR;
                NWR_HDR:  if (fire) nxt = NWR_DATA;
                NWR_DATA: if (fire && last_beat) nxt = NWR_WAIT;
                NWR_WAIT: if (resp_ok) nxt = READY; else if (tmo_hit) nxt = IDLE;
                default:  nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            state          <= IDLE;
            tid            <= 8'h00;
            wait_tid       <= 8'h00;
            pkt_cnt        <= 16'h0000;
            beat_cnt       <= '0;
            tmo_cnt        <= '0;
            nwr_done_o     <= 1'b0;
            iresp_tready_o <= 1'b0;
        end else begin
            state          <= nxt;
            iresp_tready_o <= 1'b1;
            if (state != NWR_DATA)
                beat_cnt <= '0;
            else if (fire)
                beat_cnt <= beat_cnt + 1'b1;
            if (sent) begin
                wait_tid <= tid;
                tid      <= tid + 8'h01;
            end
            if (state == DB_WAIT || state == NWR_WAIT)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
            nwr_done_o <= (state == NWR_WAIT) && link_initialized && resp_ok;
            if ((state == NWR_WAIT) && link_initialized && resp_ok)
                pkt_cnt <= pkt_cnt + 16'h0001;
        end
    end

endmodule

// File: tb/tb_srio_nwr_req.sv
module tb_srio_nwr_req;

    logic        log_clk, log_rst_n;
    logic [15:0] src_id, des_id;
    logic        link_initialized, self_check_in, nwr_req_in;
    logic        rapidIO_ready_o, nwr_ready_o, nwr_busy_o, nwr_done_o;
    logic        ireq_tvalid_o, ireq_tready_in, ireq_tlast_o;
    logic [63:0] ireq_tdata_o;
    logic [7:0]  ireq_tkeep_o;
    logic [31:0] ireq_tuser_o;
    logic        iresp_tvalid_in, iresp_tready_o, iresp_tlast_in;
    logic [63:0] iresp_tdata_in;
    logic [7:0]  iresp_tkeep_in;
    logic [31:0] iresp_tuser_in;

    int n_chk = 0;
    int n_fail = 0;

    srio_nwr_req dut (
        .log_clk(log_clk), .log_rst_n(log_rst_n),
        .src_id(src_id), .des_id(des_id),
        .link_initialized(link_initialized),
        .self_check_in(self_check_in), .nwr_req_in(nwr_req_in),
        .rapidIO_ready_o(rapidIO_ready_o), .nwr_ready_o(nwr_ready_o),
        .nwr_busy_o(nwr_busy_o), .nwr_done_o(nwr_done_o),
        .ireq_tvalid_o(ireq_tvalid_o), .ireq_tready_in(ireq_tready_in),
        .ireq_tlast_o(ireq_tlast_o), .ireq_tdata_o(ireq_tdata_o),
        .ireq_tkeep_o(ireq_tkeep_o), .ireq_tuser_o(ireq_tuser_o),
        .iresp_tvalid_in(iresp_tvalid_in), .iresp_tready_o(iresp_tready_o),
        .iresp_tlast_in(iresp_tlast_in), .iresp_tdata_in(iresp_tdata_in),
        .iresp_tkeep_in(iresp_tkeep_in), .iresp_tuser_in(iresp_tuser_in)
    );

    initial log_clk = 1'b0;
    always #5 log_clk = ~log_clk;

    typedef struct {
        logic        link, sc, nr, trdy, rv;
        logic [63:0] rd;
        logic        ev, el;
        logic [63:0] ed;
        logic        erdy, enr, ebusy;
    } vec_t;

    vec_t vecs[11];

    localparam logic [63:0] DB_T0  = 64'h00A0_2000_0100_0000;
    localparam logic [63:0] HDR_T1 = 64'h0155_2FF0_0000_0000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge log_clk);
        #1;
    endtask

    function automatic logic [63:0] dbeat(input logic [15:0] pc, input int k);
        return {16'h0001, 16'h00F0, pc, 16'(k)};
    endfunction

    initial begin
        int cnt, bad, dones;
        log_rst_n = 1'b0; src_id = 16'h0001; des_id = 16'h00F0;
        link_initialized = 1'b0; self_check_in = 1'b0; nwr_req_in = 1'b0;
        ireq_tready_in = 1'b0; iresp_tvalid_in = 1'b0; iresp_tlast_in = 1'b0;
        iresp_tdata_in = '0; iresp_tkeep_in = '0; iresp_tuser_in = '0;

        //           link sc nr trdy rv rd                    ev el ed       rdy nr busy
        vecs[0]  = '{1, 1, 0, 0, 0, 64'h0,                 0, 0, 64'h0,      0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0, 64'h0,                 1, 1, DB_T0,      0, 0, 0};
        vecs[2]  = '{1, 0, 0, 1, 0, 64'h0,                 1, 1, DB_T0,      0, 0, 0};
        vecs[3]  = '{1, 0, 0, 1, 1, 64'h01D0_0000_0000_0000, 0, 0, 64'h0,    0, 0, 0};
        vecs[4]  = '{1, 0, 0, 1, 1, 64'h00D0_0000_0000_0000, 0, 0, 64'h0,    0, 0, 0};
        vecs[5]  = '{1, 0, 0, 1, 0, 64'h0,                 0, 0, 64'h0,      1, 1, 0};
        vecs[6]  = '{1, 0, 1, 1, 0, 64'h0,                 0, 0, 64'h0,      1, 1, 0};
        vecs[7]  = '{1, 0, 0, 1, 0, 64'h0,                 1, 0, HDR_T1,     1, 0, 1};
        vecs[8]  = '{1, 0, 0, 1, 0, 64'h0,                 1, 0, dbeat(0,0), 1, 0, 1};
        vecs[9]  = '{1, 0, 0, 0, 0, 64'h0,                 1, 0, dbeat(0,1), 1, 0, 1};
        vecs[10] = '{1, 0, 0, 1, 0, 64'h0,                 1, 0, dbeat(0,1), 1, 0, 1};

        #12;
        chk("rst_tvalid", ireq_tvalid_o, 0);
        chk("rst_iresp_tready", iresp_tready_o, 0);
        chk("rst_status", {rapidIO_ready_o, nwr_ready_o, nwr_busy_o, nwr_done_o}, 0);
        log_rst_n = 1'b1;
        step();
        chk("iresp_tready_after_rst", iresp_tready_o, 1);

        // Doorbell self-check, then first NWRITE header and two beats.
        for (int i = 0; i < 11; i++) begin
            link_initialized = vecs[i].link; self_check_in = vecs[i].sc;
            nwr_req_in = vecs[i].nr; ireq_tready_in = vecs[i].trdy;
            iresp_tvalid_in = vecs[i].rv; iresp_tdata_in = vecs[i].rd;
            #1;
            chk($sformatf("v%0d_tvalid", i), ireq_tvalid_o, vecs[i].ev);
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_tdata", i), ireq_tdata_o, vecs[i].ed);
                chk($sformatf("v%0d_tlast", i), ireq_tlast_o, vecs[i].el);
                chk($sformatf("v%0d_tkeep", i), ireq_tkeep_o, 8'hFF);
                chk($sformatf("v%0d_tuser", i), ireq_tuser_o, 32'h000100F0);
            end
            chk($sformatf("v%0d_rdy", i), rapidIO_ready_o, vecs[i].erdy);
            chk($sformatf("v%0d_nwr_ready", i), nwr_ready_o, vecs[i].enr);
            chk($sformatf("v%0d_busy", i), nwr_busy_o, vecs[i].ebusy);
            step();
        end
        self_check_in = 0; nwr_req_in = 0; iresp_tvalid_in = 0;

        // Remaining beats with random back-pressure.
        for (int k = 2; k < 32; k++) begin
            int tries;
            tries = 0;
            do begin
                ireq_tready_in = (tries >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                #1;
                chk($sformatf("b%0d_tvalid", k), ireq_tvalid_o, 1);
                chk($sformatf("b%0d_tdata", k), ireq_tdata_o, dbeat(0, k));
                chk($sformatf("b%0d_tlast", k), ireq_tlast_o, k == 31);
                tries++;
                step();
            end while (!ireq_tready_in);
        end

        // NWR_WAIT: wrong TID ignored, right TID gives one done pulse.
        ireq_tready_in = 1;
        chk("wait_tvalid", ireq_tvalid_o, 0);
        chk("wait_busy", nwr_busy_o, 1);
        dones = 0;
        iresp_tvalid_in = 1; iresp_tdata_in = 64'h00D0_0000_0000_0000;
        step();
        dones += nwr_done_o;
        chk("wrong_tid_busy", nwr_busy_o, 1);
        iresp_tdata_in = 64'h01D0_0000_0000_0000;
        step();
        iresp_tvalid_in = 0;
        chk("done_pulse", nwr_done_o, 1);
        chk("done_nwr_ready", nwr_ready_o, 1);
        dones += nwr_done_o;
        nwr_req_in = 1;
        step();
        nwr_req_in = 0;
        dones += nwr_done_o;
        chk("done_count", dones, 1);

        // Second packet: TID 2, ADDR 0x100, then no response -> timeout.
        #1;
        chk("hdr2", ireq_tdata_o, 64'h0255_2FF0_0000_0100);
        for (int b = 0; b < 32; b++) begin
            step();
            if (ireq_tvalid_o !== 1'b1 || ireq_tdata_o !== dbeat(1, b) || ireq_tlast_o !== (b == 31))
                chk($sformatf("p2_beat%0d", b), {ireq_tvalid_o, ireq_tlast_o, ireq_tdata_o[15:0]},
                    {1'b1, b == 31, 16'(b)});
        end
        chk("p2_last_beat", ireq_tdata_o, dbeat(1, 31));
        step();
        cnt = 0;
        for (int i = 0; i < 2000 && rapidIO_ready_o; i++) begin
            cnt++;
            step();
        end
        chk("nwr_timeout_cycles", cnt, 1024);
        chk("tmo_rdy", rapidIO_ready_o, 0);
        chk("tmo_busy", nwr_busy_o, 0);

        // Doorbell with no response stays not-ready.
        self_check_in = 1;
        step();
        self_check_in = 0;
        chk("db_tid3", ireq_tdata_o, 64'h03A0_2000_0100_0000);
        step();
        bad = 0;
        for (int i = 0; i < 1100; i++) begin
            if (rapidIO_ready_o) bad++;
            step();
        end
        chk("db_tmo_never_ready", bad, 0);
        iresp_tvalid_in = 1; iresp_tdata_in = 64'h03D0_0000_0000_0000;
        step();
        iresp_tvalid_in = 0;
        chk("late_resp_ignored", rapidIO_ready_o, 0);

        // Successful self-check with TID 4.
        self_check_in = 1;
        step();
        self_check_in = 0;
        chk("db_tid4", ireq_tdata_o, 64'h04A0_2000_0100_0000);
        step();
        iresp_tvalid_in = 1; iresp_tdata_in = 64'h04D0_0000_0000_0000;
        step();
        iresp_tvalid_in = 0;
        chk("db4_ready", {rapidIO_ready_o, nwr_ready_o}, 2'b11);

        // Link drop mid-data.
        nwr_req_in = 1;
        step();
        nwr_req_in = 0;
        chk("hdr_tid5", ireq_tdata_o, 64'h0555_2FF0_0000_0100);
        step();
        chk("p_drop_beat0", ireq_tdata_o, dbeat(1, 0));
        step();
        step();
        link_initialized = 0;
        #1;
        chk("drop_tvalid_now", ireq_tvalid_o, 0);
        step();
        chk("drop_next", {ireq_tvalid_o, rapidIO_ready_o, nwr_ready_o, nwr_busy_o, nwr_done_o}, 0);
        link_initialized = 1;
        step();
        self_check_in = 1;
        step();
        self_check_in = 0;
        chk("db_tid5_after_drop", ireq_tdata_o, 64'h05A0_2000_0100_0000);
        step();
        iresp_tvalid_in = 1; iresp_tdata_in = 64'h05D0_0000_0000_0000;
        step();
        iresp_tvalid_in = 0;
        chk("relink_ready", rapidIO_ready_o, 1);
        nwr_req_in = 1;
        step();
        nwr_req_in = 0;
        chk("hdr_tid6", ireq_tdata_o, 64'h0655_2FF0_0000_0100);
        step();
        chk("relink_beat0", ireq_tdata_o, dbeat(1, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
